// File: rtl/arp_resolver_pkg.sv
// Shared types and constants for the ARP resolver slice.
// Holds the FSM state encoding, the broadcast addresses and the broadcast-IP check.
`timescale 1ns/1ps
package arp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLASSIFY,
    ST_QUERY,
    ST_WAIT_CACHE,
    ST_SEND_REQ,
    ST_WAIT_RETRY,
    ST_RESPOND
  } arp_state_e;

  localparam logic [47:0] ETH_BCAST_MAC = 48'hFFFF_FFFF_FFFF;
  localparam logic [31:0] IP_BCAST      = 32'hFFFF_FFFF;
  // Long enough for the cache's two-stage write to land before the re-query.
  localparam logic [31:0] REPLY_SETTLE  = 32'd3;

  function automatic logic is_bcast_ip(input logic [31:0] ip,
                                       input logic [31:0] local_ip,
                                       input logic [31:0] mask);
    return (ip == IP_BCAST) || (ip == (local_ip | ~mask));
  endfunction

endpackage

// File: rtl/arp_resolver_if.sv
// Handshake bundle around the resolver: request/response, cache query,
// cache write, received replies and the who-has broadcast request.
`timescale 1ns/1ps
interface arp_resolver_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_ip;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_error;
  logic [47:0] resp_mac;
  logic        cache_query_valid;
  logic        cache_query_ready;
  logic [31:0] cache_query_ip;
  logic        cache_resp_valid;
  logic        cache_resp_ready;
  logic        cache_resp_error;
  logic [47:0] cache_resp_mac;
  logic        rx_reply_valid;
  logic        rx_reply_ready;
  logic [31:0] rx_reply_ip;
  logic [47:0] rx_reply_mac;
  logic        cache_write_valid;
  logic        cache_write_ready;
  logic [31:0] cache_write_ip;
  logic [47:0] cache_write_mac;
  logic        tx_req_valid;
  logic        tx_req_ready;
  logic [31:0] tx_req_ip;

  // Resolver side.
  modport slave (
    input  req_valid, req_ip, resp_ready, cache_query_ready,
           cache_resp_valid, cache_resp_error, cache_resp_mac,
           rx_reply_valid, rx_reply_ip, rx_reply_mac, cache_write_ready, tx_req_ready,
    output req_ready, resp_valid, resp_error, resp_mac, cache_query_valid, cache_query_ip,
           cache_resp_ready, rx_reply_ready, cache_write_valid, cache_write_ip,
           cache_write_mac, tx_req_valid, tx_req_ip
  );

  // Surrounding IP path, cache and frame generator.
  modport master (
    output req_valid, req_ip, resp_ready, cache_query_ready,
           cache_resp_valid, cache_resp_error, cache_resp_mac,
           rx_reply_valid, rx_reply_ip, rx_reply_mac, cache_write_ready, tx_req_ready,
    input  req_ready, resp_valid, resp_error, resp_mac, cache_query_valid, cache_query_ip,
           cache_resp_ready, rx_reply_ready, cache_write_valid, cache_write_ip,
           cache_write_mac, tx_req_valid, tx_req_ip
  );
endinterface

// File: rtl/arp_resolver_timer.sv
// Loadable down-counter that parks at zero; zero_o drives the retry wake-up.
`timescale 1ns/1ps
module arp_retry_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);
  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i)
      count_d = load_val_i;
    else if (dec_i && (count_q != '0))
      count_d = count_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign zero_o = (count_q == '0);
endmodule

// File: rtl/arp_resolver.sv
// IP-to-MAC resolver in front of arp_cache: queries the cache, broadcasts
// who-has on a miss and retries on a timer; replies pass straight to the cache.
//
// state       | meaning
// IDLE        | accepting a resolution request
// CLASSIFY    | broadcast check, pick direct or gateway lookup IP
// QUERY       | presenting lookup IP to the cache
// WAIT_CACHE  | waiting for the cache answer
// SEND_REQ    | asking the frame generator for a who-has broadcast
// WAIT_RETRY  | retry interval running (shortened by a matching reply)
// RESPOND     | presenting the result
`timescale 1ns/1ps
module arp_resolver
  import arp_pkg::*;
#(
  parameter int unsigned RETRY_COUNT    = 4,
  parameter int unsigned RETRY_INTERVAL = 125000000
) (
  input  logic                clk,
  input  logic                rst,
  arp_resolver_if.slave       arp_s,
  input  logic [31:0]         local_ip_i,
  input  logic [31:0]         gateway_ip_i,
  input  logic [31:0]         subnet_mask_i
);
  localparam int          RW           = (RETRY_COUNT < 2) ? 1 : $clog2(RETRY_COUNT + 1);
  localparam logic [RW-1:0] RETRY_INIT = RW'(RETRY_COUNT);
  localparam logic [31:0] RETRY_RELOAD = 32'(RETRY_INTERVAL - 1);

  arp_state_e    state_q, state_d;
  logic [31:0]   ip_q, ip_d;
  logic [31:0]   lookup_q, lookup_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [47:0]   mac_q, mac_d;
  logic          err_q, err_d;

  logic        req_ready, resp_valid, query_valid, cresp_ready, tx_valid;
  logic        t_load, t_dec, t_zero, reply_hit;
  logic [31:0] t_val;

  assign arp_s.cache_write_valid = arp_s.rx_reply_valid;
  assign arp_s.rx_reply_ready    = arp_s.cache_write_ready;
  assign arp_s.cache_write_ip    = arp_s.rx_reply_ip;
  assign arp_s.cache_write_mac   = arp_s.rx_reply_mac;

  assign reply_hit = (state_q == ST_WAIT_RETRY) && arp_s.rx_reply_valid &&
                     arp_s.cache_write_ready && (arp_s.rx_reply_ip == lookup_q);

  arp_retry_timer #(.W(32)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (t_load),
    .load_val_i (t_val),
    .dec_i      (t_dec),
    .zero_o     (t_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ip_q     <= '0;
      lookup_q <= '0;
      retry_q  <= '0;
      mac_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ip_q     <= ip_d;
      lookup_q <= lookup_d;
      retry_q  <= retry_d;
      mac_q    <= mac_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ip_d     = ip_q;
    lookup_d = lookup_q;
    retry_d  = retry_q;
    mac_d    = mac_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: if (arp_s.req_valid) begin
        ip_d    = arp_s.req_ip;
        state_d = ST_CLASSIFY;
      end
      ST_CLASSIFY: begin
        if (is_bcast_ip(ip_q, local_ip_i, subnet_mask_i)) begin
          mac_d   = ETH_BCAST_MAC;
          err_d   = 1'b0;
          state_d = ST_RESPOND;
        end else begin
          // Off-subnet destinations resolve to the gateway's MAC.
          if ((ip_q & subnet_mask_i) != (local_ip_i & subnet_mask_i))
            lookup_d = gateway_ip_i;
          else
            lookup_d = ip_q;
          retry_d = RETRY_INIT;
          state_d = ST_QUERY;
        end
      end
      ST_QUERY: if (arp_s.cache_query_ready) state_d = ST_WAIT_CACHE;
      ST_WAIT_CACHE: if (arp_s.cache_resp_valid) begin
        if (!arp_s.cache_resp_error) begin
          mac_d   = arp_s.cache_resp_mac;
          err_d   = 1'b0;
          state_d = ST_RESPOND;
        end else if (retry_q == '0) begin
          mac_d   = '0;
          err_d   = 1'b1;
          state_d = ST_RESPOND;
        end else begin
          state_d = ST_SEND_REQ;
        end
      end
      ST_SEND_REQ: if (arp_s.tx_req_ready) begin
        retry_d = retry_q - RW'(1);
        state_d = ST_WAIT_RETRY;
      end
      ST_WAIT_RETRY: if (t_zero) state_d = ST_QUERY;
      ST_RESPOND: if (arp_s.resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    query_valid = 1'b0;
    cresp_ready = 1'b0;
    tx_valid    = 1'b0;
    t_load      = 1'b0;
    t_dec       = 1'b0;
    t_val       = RETRY_RELOAD;
    case (state_q)
      ST_IDLE:       req_ready   = !rst;
      ST_QUERY:      query_valid = 1'b1;
      ST_WAIT_CACHE: cresp_ready = 1'b1;
      ST_SEND_REQ: begin
        tx_valid = 1'b1;
        t_load   = arp_s.tx_req_ready;
      end
      ST_WAIT_RETRY: begin
        t_dec = 1'b1;
        if (reply_hit) begin
          t_load = 1'b1;
          t_val  = REPLY_SETTLE;
        end
      end
      ST_RESPOND:    resp_valid  = 1'b1;
      default: ;
    endcase
  end

  assign arp_s.req_ready         = req_ready;
  assign arp_s.resp_valid        = resp_valid;
  assign arp_s.resp_error        = err_q;
  assign arp_s.resp_mac          = mac_q;
  assign arp_s.cache_query_valid = query_valid;
  assign arp_s.cache_query_ip    = lookup_q;
  assign arp_s.cache_resp_ready  = cresp_ready;
  assign arp_s.tx_req_valid      = tx_valid;
  assign arp_s.tx_req_ip         = lookup_q;
endmodule

// File: tb/tb_arp_resolver.sv
// Directed bench for arp_resolver with a small two-cycle arp_cache model
// and a scoreboard queue of expected resolution results.
`timescale 1ns/1ps
module tb_arp_resolver;
  import arp_pkg::*;

  localparam logic [31:0] LOCAL_IP = 32'hC0A8_0164;   // 192.168.1.100
  localparam logic [31:0] MASK     = 32'hFFFF_FF00;
  localparam logic [31:0] GW_IP    = 32'hC0A8_0101;   // 192.168.1.1
  localparam logic [31:0] IP_A     = 32'hC0A8_010A;   // 192.168.1.10
  localparam logic [47:0] MAC_A    = 48'h0200_0000_000A;
  localparam logic [47:0] MAC_GW   = 48'h0200_0000_0001;
  localparam logic [31:0] IP_MISS  = 32'hC0A8_0114;   // 192.168.1.20
  localparam logic [47:0] MAC_MISS = 48'h0200_0000_0014;

  typedef struct packed { logic [47:0] mac; logic err; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] local_ip, gateway_ip, subnet_mask;
  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];

  arp_resolver_if arp();

  arp_resolver #(.RETRY_COUNT(2), .RETRY_INTERVAL(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .arp_s         (arp),
    .local_ip_i    (local_ip),
    .gateway_ip_i  (gateway_ip),
    .subnet_mask_i (subnet_mask)
  );

  always #5 clk = ~clk;

  // Cache / frame-generator model: lookup answers two edges after the query.
  int cyc = 0, nq = 0, ntx = 0, pend = 0, tbl_n = 0, tx_last = 0, tx_prev = 0;
  logic [31:0] last_qip = '0, last_txip = '0;
  logic [31:0] tbl_ip [8];
  logic [47:0] tbl_mac [8];

  function automatic logic [48:0] lookup(input logic [31:0] ip);
    for (int i = 0; i < 8; i++)
      if (i < tbl_n && tbl_ip[i] == ip) return {1'b1, tbl_mac[i]};
    return '0;
  endfunction

  always @(posedge clk) begin
    logic [48:0] hit;
    cyc <= cyc + 1;
    if (rst) begin
      arp.cache_resp_valid <= 1'b0;
      arp.cache_resp_error <= 1'b0;
      arp.cache_resp_mac   <= '0;
      pend       <= 0;
      tbl_ip[0]  <= IP_A;  tbl_mac[0] <= MAC_A;
      tbl_ip[1]  <= GW_IP; tbl_mac[1] <= MAC_GW;
      tbl_n      <= 2;
    end else begin
      if (arp.cache_query_valid && arp.cache_query_ready) begin
        nq       <= nq + 1;
        last_qip <= arp.cache_query_ip;
        pend     <= 1;
      end
      if (pend == 1) begin
        hit = lookup(last_qip);
        pend <= 0;
        arp.cache_resp_valid <= 1'b1;
        arp.cache_resp_error <= !hit[48];
        arp.cache_resp_mac   <= hit[48] ? hit[47:0] : 48'h0;
      end
      if (arp.cache_resp_valid && arp.cache_resp_ready) arp.cache_resp_valid <= 1'b0;
      if (arp.cache_write_valid && arp.cache_write_ready && tbl_n < 8) begin
        tbl_ip[tbl_n[2:0]]  <= arp.cache_write_ip;
        tbl_mac[tbl_n[2:0]] <= arp.cache_write_mac;
        tbl_n <= tbl_n + 1;
      end
      if (arp.tx_req_valid && arp.tx_req_ready) begin
        ntx       <= ntx + 1;
        last_txip <= arp.tx_req_ip;
        tx_prev   <= tx_last;
        tx_last   <= cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [31:0] ip, input logic [47:0] mac, input logic err,
                         input int hold, output int lat);
    exp_t e;
    sb.push_back('{mac: mac, err: err});
    arp.resp_ready = (hold == 0);
    @(negedge clk);
    chk("req_ready_idle", 64'(arp.req_ready), 64'd1);
    arp.req_valid = 1'b1;
    arp.req_ip    = ip;
    @(negedge clk);
    arp.req_valid = 1'b0;
    lat = 1;
    while (!arp.resp_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    chk("resp_seen", 64'(arp.resp_valid), 64'd1);
    e = sb.pop_front();
    chk("resp_mac", 64'(arp.resp_mac), 64'(e.mac));
    chk("resp_error", 64'(arp.resp_error), 64'(e.err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("resp_hold_valid", 64'(arp.resp_valid), 64'd1);
      chk("resp_hold_mac", 64'(arp.resp_mac), 64'(e.mac));
    end
    arp.resp_ready = 1'b1;
    @(negedge clk);
    chk("resp_drop", 64'(arp.resp_valid), 64'd0);
    chk("req_ready_back", 64'(arp.req_ready), 64'd1);
  endtask

  task automatic wait_tx(input int base);
    int w = 0;
    while (ntx == base && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk("tx_seen", 64'(ntx != base), 64'd1);
  endtask

  task automatic inject(input logic [31:0] ip, input logic [47:0] mac);
    arp.rx_reply_valid = 1'b1;
    arp.rx_reply_ip    = ip;
    arp.rx_reply_mac   = mac;
    #1;
    chk("wr_valid", 64'(arp.cache_write_valid), 64'd1);
    chk("wr_ip", 64'(arp.cache_write_ip), 64'(ip));
    chk("wr_mac", 64'(arp.cache_write_mac), 64'(mac));
    chk("rx_ready", 64'(arp.rx_reply_ready), 64'd1);
    @(negedge clk);
    arp.rx_reply_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nq0, ntx0, idle;
    bit saw;
    local_ip = LOCAL_IP; gateway_ip = GW_IP; subnet_mask = MASK;
    arp.req_valid = 1'b0; arp.req_ip = '0; arp.resp_ready = 1'b1;
    arp.cache_query_ready = 1'b1; arp.cache_write_ready = 1'b1; arp.tx_req_ready = 1'b1;
    arp.rx_reply_valid = 1'b0; arp.rx_reply_ip = '0; arp.rx_reply_mac = '0;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(arp.req_ready), 64'd0);
    chk("rst_resp_valid", 64'(arp.resp_valid), 64'd0);
    chk("rst_query_valid", 64'(arp.cache_query_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", 64'(arp.req_ready), 64'd1);
    chk("idle_resp_mac", 64'(arp.resp_mac), 64'd0);
    chk("idle_resp_error", 64'(arp.resp_error), 64'd0);

    // Local hit
    nq0 = nq; ntx0 = ntx;
    request(IP_A, MAC_A, 1'b0, 0, lat);
    chk("hit_latency", 64'(lat), 64'd5);
    chk("hit_queries", 64'(nq - nq0), 64'd1);
    chk("hit_tx", 64'(ntx - ntx0), 64'd0);
    chk("hit_query_ip", 64'(last_qip), 64'(IP_A));

    // Subnet broadcast and limited broadcast (with response back-pressure)
    nq0 = nq;
    request(32'hC0A8_01FF, ETH_BCAST_MAC, 1'b0, 0, lat);
    chk("bcast_latency", 64'(lat), 64'd2);
    request(32'hFFFF_FFFF, ETH_BCAST_MAC, 1'b0, 3, lat);
    chk("bcast_queries", 64'(nq - nq0), 64'd0);

    // Off-subnet goes through the gateway
    request(32'h0A00_0005, MAC_GW, 1'b0, 0, lat);
    chk("gw_query_ip", 64'(last_qip), 64'(GW_IP));
    chk("gw_latency", 64'(lat), 64'd5);

    // Unresolved miss; a reply for another IP must not shorten the wait
    nq0 = nq; ntx0 = ntx;
    fork
      request(IP_MISS, 48'h0, 1'b1, 0, lat);
      begin
        wait_tx(ntx0);
        repeat (5) @(negedge clk);
        inject(32'hC0A8_0163, 48'h0200_0000_0063);
      end
    join
    chk("miss_queries", 64'(nq - nq0), 64'd3);
    chk("miss_tx", 64'(ntx - ntx0), 64'd2);
    chk("miss_tx_spacing", 64'((tx_last - tx_prev) >= 16), 64'd1);
    chk("miss_tx_ip", 64'(last_txip), 64'(IP_MISS));

    // Miss resolved by a matching reply during the retry wait
    nq0 = nq; ntx0 = ntx; idle = 0;
    fork
      request(IP_MISS, MAC_MISS, 1'b0, 0, lat);
      begin
        wait_tx(ntx0);
        repeat (5) @(negedge clk);
        inject(IP_MISS, MAC_MISS);
        while (!arp.cache_query_valid && idle < 20) begin
          idle++;
          @(negedge clk);
        end
        chk("requery_soon", 64'(idle <= 4), 64'd1);
      end
    join
    chk("reply_tx", 64'(ntx - ntx0), 64'd1);
    chk("reply_queries", 64'(nq - nq0), 64'd2);

    // Reset in the middle of a retry wait
    ntx0 = ntx;
    @(negedge clk);
    arp.req_valid = 1'b1;
    arp.req_ip    = 32'hC0A8_011E;
    @(negedge clk);
    arp.req_valid = 1'b0;
    wait_tx(ntx0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_req_ready", 64'(arp.req_ready), 64'd0);
    chk("mid_rst_valids", 64'({arp.resp_valid, arp.cache_query_valid, arp.cache_resp_ready,
                               arp.tx_req_valid, arp.cache_write_valid}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 64'(arp.req_ready), 64'd1);
    saw = 1'b0;
    repeat (30) begin
      @(negedge clk);
      saw |= arp.resp_valid | arp.cache_query_valid | arp.tx_req_valid;
    end
    chk("post_rst_quiet", 64'(saw), 64'd0);

    request(IP_A, MAC_A, 1'b0, 0, lat);
    chk("recover_latency", 64'(lat), 64'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/arp_resolver.md
Name: arp_resolver

Overview:
- Initiator in front of arp_cache. Takes IP-to-MAC resolution requests from the IP transmit path and queries the cache. On a miss it asks the ARP frame generator to broadcast a request, then retries on a timer until the cache hits or retries run out.
- Forwards received ARP replies into the cache write port.
- Sits between ip_complete/eth TX logic and arp_cache/ARP frame TX.

Parameters:
- RETRY_COUNT, 4: ARP request broadcasts sent before returning an error.
- RETRY_INTERVAL, 125000000: clk cycles between broadcasts. Width 32, minimum 4.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  1  resolution request valid
- req_ready  out  1  resolution request accepted
- req_ip  in  32  destination IP
- resp_valid  out  1  resolution result valid
- resp_ready  in  1  result consumed
- resp_error  out  1  1 = unresolved
- resp_mac  out  48  resolved MAC; 0 on error
- cache_query_valid  out  1  to arp_cache query_request_valid
- cache_query_ready  in  1  from arp_cache query_request_ready
- cache_query_ip  out  32  IP being looked up
- cache_resp_valid  in  1  from arp_cache query_response_valid
- cache_resp_ready  out  1  to arp_cache query_response_ready
- cache_resp_error  in  1  from arp_cache query_response_error
- cache_resp_mac  in  48  from arp_cache query_response_mac
- rx_reply_valid  in  1  parsed ARP reply valid
- rx_reply_ready  out  1  parsed ARP reply accepted
- rx_reply_ip  in  32  sender IP of the reply
- rx_reply_mac  in  48  sender MAC of the reply
- cache_write_valid  out  1  to arp_cache write_request_valid
- cache_write_ready  in  1  from arp_cache write_request_ready
- cache_write_ip  out  32  IP to write
- cache_write_mac  out  48  MAC to write
- tx_req_valid  out  1  request to broadcast an ARP who-has
- tx_req_ready  in  1  frame generator accepted
- tx_req_ip  out  32  target IP of the broadcast
- local_ip  in  32  this node's IP
- gateway_ip  in  32  default gateway IP
- subnet_mask  in  32  local subnet mask

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. All valid outputs = 0. req_ready = 0, resp_error = 0, resp_mac = 0, FSM = IDLE, retry counter = 0, timer = 0.
- Handshakes: every interface is AXI-style valid/ready.
  - Transfer occurs when valid && ready on a rising clk edge.
  - Once valid is raised, the source holds valid and data stable until the transfer.
- Reply path: combinational pass-through, independent of the FSM.
  - cache_write_valid = rx_reply_valid; rx_reply_ready = cache_write_ready.
  - cache_write_ip/mac = rx_reply_ip/mac.
- FSM states: IDLE, CLASSIFY, QUERY, WAIT_CACHE, SEND_REQ, WAIT_RETRY, RESPOND.
- IDLE: req_ready = 1. On handshake, latch req_ip → CLASSIFY.
- CLASSIFY (1 cycle):
  - If ip == 32'hFFFFFFFF or ip == (local_ip | ~subnet_mask): set mac = 48'hFFFFFFFFFFFF, error = 0 → RESPOND.
  - Else if (ip & subnet_mask) != (local_ip & subnet_mask): lookup IP = gateway_ip.
  - Else lookup IP = ip.
  - Retry counter = RETRY_COUNT → QUERY.
- QUERY: drive cache_query_valid with the lookup IP. On handshake → WAIT_CACHE.
- WAIT_CACHE: cache_resp_ready = 1. On handshake:
  - If !cache_resp_error: latch mac, error = 0 → RESPOND.
  - Else if retry counter == 0: mac = 0, error = 1 → RESPOND.
  - Else → SEND_REQ.
- SEND_REQ: tx_req_valid = 1 with tx_req_ip = lookup IP. On handshake:
  - Decrement retry counter.
  - Timer = RETRY_INTERVAL-1 → WAIT_RETRY.
- WAIT_RETRY:
  - Timer decrements each cycle; at 0 → QUERY.
  - If a reply-path transfer occurs with rx_reply_ip == lookup IP, load timer = 3. Three cycles is enough for the cache's two-stage write to land before the re-query.
- RESPOND: resp_valid = 1. On handshake → IDLE; req_ready is raised the next cycle.
- Latency:
  - Cache hit: request handshake to resp_valid = 5 cycles when every ready is held high.
  - Broadcast address: 2 cycles.
- Boundary conditions:
  - RETRY_COUNT = 0 gives a single query only; no broadcasts are sent.
  - A reply for a different IP only updates the cache; the timer is not changed.
  - A reply arriving in any state other than WAIT_RETRY only updates the cache.
  - rst mid-transaction aborts everything; no response is emitted.
  - Config inputs are sampled only in CLASSIFY.

Decomposition:
- Shared package arp_pkg: state enum, ETH_BCAST_MAC = 48'hFFFFFFFFFFFF, IP_BCAST = 32'hFFFFFFFF.
- Natural sub-module: arp_retry_timer, a loadable down-counter with a zero flag.

Test Plan:
- Cache preloaded with 192.168.1.10→02:00:00:00:00:0A; local 192.168.1.100/24; request 192.168.1.10 → one query, resp mac 02:00:00:00:00:0A, error 0, latency 5, no tx_req.
- Request 192.168.1.255 → resp mac FF:FF:FF:FF:FF:FF, error 0, no cache query.
- Request 10.0.0.5 with gateway 192.168.1.1 cached → cache_query_ip = 192.168.1.1, resp is the gateway MAC.
- Miss on 192.168.1.20, no reply, RETRY_COUNT = 2, RETRY_INTERVAL = 16 → 3 queries, 2 tx_req spaced ≥16 cycles apart, resp error = 1, mac = 0.
- Miss on 192.168.1.20, reply 192.168.1.20→02:..:14 injected 5 cycles into WAIT_RETRY → cache write seen, re-query within 4 cycles, resp mac 02:..:14, error 0.
- Assert rst while in WAIT_RETRY → all valids 0 next cycle, req_ready = 0 during reset, then 1 in IDLE.
